// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter feeding a single registered adder.
// NREQ requesters offer (a, b) operand pairs. One winner per free slot has
// its sum registered and presented on a valid/ready response port together
// with its index.
// Optional feature: define ADDER_ARBITER_OVF_EN to add the rsp_ovf output,
// which flags signed two's-complement overflow of the registered sum.
module adder_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NREQ-1:0]                       req_valid,
    output logic [NREQ-1:0]                       req_ready,
    input  logic [NREQ*WIDTH-1:0]                 req_a,
    input  logic [NREQ*WIDTH-1:0]                 req_b,
    output logic                                  rsp_valid,
    input  logic                                  rsp_ready,
    output logic [WIDTH-1:0]                      rsp_y,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] rsp_id
`ifdef ADDER_ARBITER_OVF_EN
    ,
    output logic                                  rsp_ovf
`endif
);

    localparam int          IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned NR  = NREQ;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDW-1:0]   last_grant;
    logic             found;
    logic [IDW-1:0]   gidx;
    logic             slot_free;
    logic             accept;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic [WIDTH-1:0] sum;
    logic             ovf;

    // Round-robin search: first valid requester starting at last_grant+1, wrapping.
    always_comb begin
        int unsigned lg_ext;
        found  = 1'b0;
        gidx   = '0;
        lg_ext = 32'(last_grant);
        for (int unsigned off = 1; off <= NR; off++) begin
            for (int unsigned i = 0; i < NR; i++) begin
                if (!found && req_valid[i] && (i == ((lg_ext + off) % NR))) begin
                    found = 1'b1;
                    gidx  = IDW'(i);
                end
            end
        end
    end

    // Slot availability and the one-hot grant; nothing is granted while reset is held.
    always_comb begin
        slot_free = (state == IDLE) || rsp_ready;
        accept    = 1'b0;
        req_ready = '0;
        if (!reset && slot_free && found) begin
            accept = 1'b1;
            for (int unsigned i = 0; i < NR; i++) begin
                req_ready[i] = (IDW'(i) == gidx);
            end
        end
    end

    // Operand mux for the winner, sum and signed-overflow detection.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            if (IDW'(i) == gidx) begin
                a_sel = req_a[i*WIDTH +: WIDTH];
                b_sel = req_b[i*WIDTH +: WIDTH];
            end
        end
        sum = a_sel + b_sel;
        ovf = (a_sel[WIDTH-1] == b_sel[WIDTH-1]) && (sum[WIDTH-1] != a_sel[WIDTH-1]);
    end

    // Next-state logic: an accepted request always lands in RESP; a consumed
    // result with nothing new to take drops back to IDLE.
    always_comb begin
        state_nxt = state;
        rsp_valid = (state == RESP);
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (accept) begin
                    state_nxt = RESP;
                end else if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Result and arbitration-pointer registers; both update only on an accepted request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_y      <= '0;
            rsp_id     <= '0;
            last_grant <= IDW'(NREQ - 1);
        end else if (accept) begin
            rsp_y      <= sum;
            rsp_id     <= gidx;
            last_grant <= gidx;
        end
    end

`ifdef ADDER_ARBITER_OVF_EN
    // Overflow flag captured alongside rsp_y.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_ovf <= 1'b0;
        end else if (accept) begin
            rsp_ovf <= ovf;
        end
    end
`else
    logic unused_ovf;
    always_comb unused_ovf = ovf;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Testbench for adder_arbiter: directed steps plus random traffic, with
// expected values taken from a behavioural model.
module tb_adder_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_y;
    logic [1:0]  rsp_id;
`ifdef ADDER_ARBITER_OVF_EN
    logic        rsp_ovf;
`endif

    adder_arbiter #(.WIDTH(8), .NREQ(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_id    (rsp_id)
`ifdef ADDER_ARBITER_OVF_EN
        ,
        .rsp_ovf   (rsp_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: a held result and the index of the last granted requester.
    bit         held;
    int         lg;
    logic [7:0] my;
    int         mid;
    bit         movf;
    logic [7:0] a_op [4];
    logic [7:0] b_op [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        held = 0;
        lg   = 3;
        my   = 8'h00;
        mid  = 0;
        movf = 0;
    endtask

    // Called at a falling edge: drive inputs, check mid-cycle, then advance the model at the rising edge.
    task automatic cycle(input logic [3:0] v, input logic rr);
        logic [3:0] er;
        int         w;
        int         c;
        int         s;
        bit         fr;
        req_valid = v;
        rsp_ready = rr;
        for (int i = 0; i < 4; i++) begin
            req_a[i*8 +: 8] = a_op[i];
            req_b[i*8 +: 8] = b_op[i];
        end
        fr = !held || rr;
        w  = -1;
        if (fr) begin
            for (int k = 1; k <= 4; k++) begin
                c = (lg + k) % 4;
                if (w < 0 && v[c]) w = c;
            end
        end
        er = (w >= 0) ? (4'b0001 << w) : 4'b0000;
        #2;
        chk("req_ready", {28'd0, req_ready}, {28'd0, er});
        chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, held});
        if (held) begin
            chk("rsp_y", {24'd0, rsp_y}, {24'd0, my});
            chk("rsp_id", {30'd0, rsp_id}, 32'(mid));
`ifdef ADDER_ARBITER_OVF_EN
            chk("rsp_ovf", {31'd0, rsp_ovf}, {31'd0, movf});
`endif
        end
        @(posedge clk);
        if (w >= 0) begin
            held = 1;
            my   = a_op[w] + b_op[w];
            mid  = w;
            lg   = w;
            s    = int'($signed(a_op[w])) + int'($signed(b_op[w]));
            movf = (s > 127) || (s < -128);
        end else if (held && rr) begin
            held = 0;
        end
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < 4; i++) begin
            a_op[i] = 8'h00;
            b_op[i] = 8'h00;
        end
        model_reset();

        // Reset state, with requests pending that must not be granted.
        #2;
        chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_y", {24'd0, rsp_y}, 32'd0);
        chk("rst_id", {30'd0, rsp_id}, 32'd0);
        chk("rst_ready", {28'd0, req_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Single request from requester 0.
        a_op[0] = 8'h05;
        b_op[0] = 8'h03;
        cycle(4'b0001, 1'b1);
        chk("single_y", {24'd0, rsp_y}, 32'h08);
        chk("single_id", {30'd0, rsp_id}, 32'd0);
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b1);

        // Round-robin with all requesters busy and the consumer always ready.
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 4; i++) begin
                a_op[i] = 8'($urandom);
                b_op[i] = 8'($urandom);
            end
            cycle(4'b1111, 1'b1);
        end

        // Backpressure: result 0x10 held for five cycles.
        for (int i = 0; i < 4; i++) begin
            a_op[i] = 8'h08;
            b_op[i] = 8'h08;
        end
        cycle(4'b1111, 1'b1);
        for (int n = 0; n < 5; n++) begin
            for (int i = 0; i < 4; i++) a_op[i] = 8'($urandom);
            cycle(4'b1111, 1'b0);
            chk("bp_hold_y", {24'd0, rsp_y}, 32'h10);
        end
        cycle(4'b1111, 1'b1);

        // Carry wrap, then signed overflow.
        a_op[1] = 8'hFF;
        b_op[1] = 8'h01;
        cycle(4'b0010, 1'b1);
        chk("wrap_y", {24'd0, rsp_y}, 32'h00);
        a_op[1] = 8'h7F;
        b_op[1] = 8'h01;
        cycle(4'b0010, 1'b1);
        chk("ovf_y", {24'd0, rsp_y}, 32'h80);
`ifdef ADDER_ARBITER_OVF_EN
        chk("ovf_flag", {31'd0, rsp_ovf}, 32'd1);
`endif
        cycle(4'b0000, 1'b1);

        // Random traffic.
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 4; i++) begin
                a_op[i] = 8'($urandom);
                b_op[i] = 8'($urandom);
            end
            cycle(4'($urandom), ($urandom_range(0, 3) != 0));
        end

        // Reset while a result is held: it must vanish before the next edge.
        a_op[0] = 8'h11;
        b_op[0] = 8'h22;
        cycle(4'b0001, 1'b0);
        chk("pre_rst_valid", {31'd0, rsp_valid}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rst_y", {24'd0, rsp_y}, 32'd0);
        chk("mid_rst_ready", {28'd0, req_ready}, 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        cycle(4'b1100, 1'b1);
        chk("post_rst_id", {30'd0, rsp_id}, 32'd2);
        cycle(4'b0000, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
